// File: rtl/irq_ctrl.sv
// Two-source interrupt controller: synchronised edge capture, priority entry sequencing and RETI unwinding.
// Define IRQ_NEST_EN to let irq0 preempt a running irq1 handler; the default build forbids nesting.
module irq_ctrl #(
  parameter logic [5:0] EI_OP   = 6'b111100,
  parameter logic [5:0] DI_OP   = 6'b111101,
  parameter logic [5:0] RETI_OP = 6'b111110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq0,
  input  logic       irq1,
  input  logic [5:0] opcode,
  output logic [1:0] s_interrupcion,
  output logic       irq_push,
  output logic       squash,
  output logic       ie,
  output logic [1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ENTER0 = 2'b01,
    ENTER1 = 2'b10,
    SERV   = 2'b11
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] sync_p2;
  logic [1:0] rise;
  logic [1:0] pend;
  logic [1:0] pend_nxt;
  logic [1:0] in_service_nxt;
  logic       ie_nxt;
  logic       in_enter;
  logic       nest_ok;
  logic       go0;
  logic       go1;

  // bit0 carries irq0, bit1 carries irq1; sync_p2 only serves the rising-edge detector
  assign rise = sync_p1 & ~sync_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0    <= 2'b00;
      sync_p1    <= 2'b00;
      sync_p2    <= 2'b00;
      state      <= IDLE;
      pend       <= 2'b00;
      in_service <= 2'b00;
      ie         <= 1'b0;
    end else begin
      sync_p0    <= {irq1, irq0};
      sync_p1    <= sync_p0;
      sync_p2    <= sync_p1;
      state      <= state_nxt;
      pend       <= pend_nxt;
      in_service <= in_service_nxt;
      ie         <= ie_nxt;
    end
  end

  always_comb begin
    in_enter       = (state == ENTER0) || (state == ENTER1);
    s_interrupcion = 2'b00;
    if (state == ENTER0) s_interrupcion = 2'b01;
    if (state == ENTER1) s_interrupcion = 2'b10;
    irq_push       = in_enter;
    squash         = in_enter;

    ie_nxt = ie;
    if (!in_enter) begin
      if (opcode == EI_OP)      ie_nxt = 1'b1;
      else if (opcode == DI_OP) ie_nxt = 1'b0;
    end

    pend_nxt       = pend;
    in_service_nxt = in_service;
    state_nxt      = state;
    case (state)
      ENTER0: begin
        pend_nxt[0]       = 1'b0;
        in_service_nxt[0] = 1'b1;
        state_nxt         = SERV;
      end
      ENTER1: begin
        pend_nxt[1]       = 1'b0;
        in_service_nxt[1] = 1'b1;
        state_nxt         = SERV;
      end
      SERV: begin
        if (opcode == RETI_OP) begin
          if (in_service[0]) in_service_nxt[0] = 1'b0;
          else               in_service_nxt[1] = 1'b0;
          state_nxt = (in_service_nxt == 2'b00) ? IDLE : SERV;
        end
      end
      default: ;
    endcase

    // A new edge wins over the clear so a request arriving during entry is not lost
    pend_nxt = pend_nxt | rise;

    // Eligibility looks at the post-edge ie/pend/in_service so entry starts the cycle they take effect
`ifdef IRQ_NEST_EN
    nest_ok = ~in_service_nxt[0];
`else
    nest_ok = (in_service_nxt == 2'b00);
`endif
    go0 = ~in_enter & ie_nxt & pend_nxt[0] & nest_ok;
    go1 = ~in_enter & ie_nxt & pend_nxt[1] & (in_service_nxt == 2'b00) & ~go0;
    if (go0)      state_nxt = ENTER0;
    else if (go1) state_nxt = ENTER1;
  end

endmodule
